// File: rtl/clasif_pkg.sv
// Shared definitions for the sequential coffee-bean grader: grade encodings,
// FSM states and the grading rule applied to the voted sensor bits.
package clasif_pkg;

  localparam logic [1:0] GRADE_BAJA  = 2'b00;
  localparam logic [1:0] GRADE_MEDIA = 2'b01;
  localparam logic [1:0] GRADE_ALTA  = 2'b10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SAMPLE     = 2'd1,
    EJECT      = 2'd2,
    WAIT_CLEAR = 2'd3
  } state_t;

  // A bean needs both size and weight to leave BAJA; colour lifts it to ALTA.
  function automatic logic [1:0] grade_rule(input logic t, input logic p, input logic c);
    if (!t || !p) return GRADE_BAJA;
    else if (!c)  return GRADE_MEDIA;
    else          return GRADE_ALTA;
  endfunction

endpackage

// File: rtl/clasificador_secuencial_if.sv
// Sensor/actuator bundle between the sensing station, the grader and the sorting gates.
interface clasificador_secuencial_if #(
  parameter int CNT_W = 16
);
  // grade_valid is a one-cycle strobe with no ready: grade is new on the cycle
  // it is high and holds until the next strobe; there is no back-pressure.
  logic             bean_present;
  logic             sensor_tamano;
  logic             sensor_peso;
  logic             sensor_color;
  logic             clear_counts;
  logic             busy;
  logic             grade_valid;
  logic [1:0]       grade;
  logic             eject_baja;
  logic             eject_media;
  logic             eject_alta;
  logic [CNT_W-1:0] cnt_baja;
  logic [CNT_W-1:0] cnt_media;
  logic [CNT_W-1:0] cnt_alta;

  modport master (
    output bean_present, sensor_tamano, sensor_peso, sensor_color, clear_counts,
    input  busy, grade_valid, grade, eject_baja, eject_media, eject_alta,
           cnt_baja, cnt_media, cnt_alta
  );

  modport slave (
    input  bean_present, sensor_tamano, sensor_peso, sensor_color, clear_counts,
    output busy, grade_valid, grade, eject_baja, eject_media, eject_alta,
           cnt_baja, cnt_media, cnt_alta
  );
endinterface

// File: rtl/voto_mayoria.sv
// Single-sensor sample accumulator with threshold vote; the vote includes the
// sample being taken this cycle so the grade can be registered on the last edge.
module voto_mayoria #(
  parameter int SAMPLES = 4,
  parameter int VOTE_TH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sample,
  output logic vote
);
  localparam int ACC_W = $clog2(SAMPLES + 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum  = {1'b0, acc} + {{ACC_W{1'b0}}, (en & sample)};
  assign vote = (sum >= (ACC_W + 1)'(VOTE_TH));

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= sum[ACC_W-1:0];
  end
endmodule

// File: rtl/clasificador_secuencial.sv
// Sequential bean grader: majority-voted sampling window, registered grade,
// timed one-hot ejector pulse and saturating per-grade tallies.
module clasificador_secuencial
  import clasif_pkg::*;
#(
  parameter int SAMPLES      = 4,
  parameter int VOTE_TH      = 3,
  parameter int EJECT_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  clasificador_secuencial_if.slave  bus,
  output state_t                    state_dbg
);
  if (SAMPLES < 2 || SAMPLES > 15) begin : g_bad_samples
    $error("SAMPLES must be in 2..15");
  end
  if (VOTE_TH < 1 || VOTE_TH > SAMPLES) begin : g_bad_vote_th
    $error("VOTE_TH must be in 1..SAMPLES");
  end
  if (EJECT_CYCLES < 1) begin : g_bad_eject
    $error("EJECT_CYCLES must be at least 1");
  end

  // One counter times both the sampling window and the eject pulse.
  localparam int CYC_MAX = (SAMPLES > EJECT_CYCLES) ? SAMPLES : EJECT_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  state_t           state;
  logic [CYC_W-1:0] cyc_cnt;
  logic             vote_t, vote_p, vote_c;
  logic             smp_en, smp_clr, window_done;
  logic [1:0]       next_grade;

  assign smp_en      = (state == SAMPLE);
  assign smp_clr     = (state == IDLE);
  assign window_done = smp_en && (cyc_cnt == CYC_W'(SAMPLES - 1));
  assign next_grade  = grade_rule(vote_t, vote_p, vote_c);
  assign bus.busy    = (state != IDLE);
  assign state_dbg   = state;

  voto_mayoria #(.SAMPLES(SAMPLES), .VOTE_TH(VOTE_TH)) u_voto_t (
    .clk(clk), .rst(rst), .clr(smp_clr), .en(smp_en), .sample(bus.sensor_tamano), .vote(vote_t)
  );
  voto_mayoria #(.SAMPLES(SAMPLES), .VOTE_TH(VOTE_TH)) u_voto_p (
    .clk(clk), .rst(rst), .clr(smp_clr), .en(smp_en), .sample(bus.sensor_peso), .vote(vote_p)
  );
  voto_mayoria #(.SAMPLES(SAMPLES), .VOTE_TH(VOTE_TH)) u_voto_c (
    .clk(clk), .rst(rst), .clr(smp_clr), .en(smp_en), .sample(bus.sensor_color), .vote(vote_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cyc_cnt         <= '0;
      bus.grade_valid <= 1'b0;
      bus.grade       <= GRADE_BAJA;
      bus.eject_baja  <= 1'b0;
      bus.eject_media <= 1'b0;
      bus.eject_alta  <= 1'b0;
      bus.cnt_baja    <= '0;
      bus.cnt_media   <= '0;
      bus.cnt_alta    <= '0;
    end else begin
      bus.grade_valid <= 1'b0;
      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          if (bus.bean_present) state <= SAMPLE;
        end
        SAMPLE: begin
          if (window_done) begin
            state           <= EJECT;
            cyc_cnt         <= '0;
            bus.grade       <= next_grade;
            bus.grade_valid <= 1'b1;
            bus.eject_baja  <= (next_grade == GRADE_BAJA);
            bus.eject_media <= (next_grade == GRADE_MEDIA);
            bus.eject_alta  <= (next_grade == GRADE_ALTA);
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        EJECT: begin
          if (cyc_cnt == CYC_W'(EJECT_CYCLES - 1)) begin
            state           <= WAIT_CLEAR;
            cyc_cnt         <= '0;
            bus.eject_baja  <= 1'b0;
            bus.eject_media <= 1'b0;
            bus.eject_alta  <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        WAIT_CLEAR: begin
          if (!bus.bean_present) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Clear has priority over the increment landing on the same edge.
      if (bus.clear_counts) begin
        bus.cnt_baja  <= '0;
        bus.cnt_media <= '0;
        bus.cnt_alta  <= '0;
      end else if (window_done) begin
        if (next_grade == GRADE_BAJA && !(&bus.cnt_baja))
          bus.cnt_baja <= bus.cnt_baja + CNT_W'(1);
        if (next_grade == GRADE_MEDIA && !(&bus.cnt_media))
          bus.cnt_media <= bus.cnt_media + CNT_W'(1);
        if (next_grade == GRADE_ALTA && !(&bus.cnt_alta))
          bus.cnt_alta <= bus.cnt_alta + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_clasificador_secuencial.sv
// Bench for clasificador_secuencial: directed beans with hand-computed grades,
// a strobe/eject monitor fed from an expected-grade queue, and counter checks.
module tb_clasificador_secuencial;
  import clasif_pkg::*;

  localparam int SAMPLES      = 4;
  localparam int VOTE_TH      = 3;
  localparam int EJECT_CYCLES = 8;
  localparam int CNT_W        = 4;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;

  clasificador_secuencial_if #(.CNT_W(CNT_W)) bus ();

  clasificador_secuencial #(
    .SAMPLES(SAMPLES), .VOTE_TH(VOTE_TH), .EJECT_CYCLES(EJECT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests   = 0;
  int fails   = 0;
  int strobes = 0;
  int n_beans = 0;

  logic [1:0] exp_q[$];
  logic [1:0] cur_grade = 2'b00;
  int         ej_len    = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pops the expected grade on each strobe, then checks the eject pulse
  always @(negedge clk) begin
    logic [2:0] ej;
    logic [2:0] exp_ej;
    ej = {bus.eject_alta, bus.eject_media, bus.eject_baja};
    if (rst) begin
      ej_len = 0;
    end else begin
      if (bus.grade_valid) begin
        strobes++;
        if (exp_q.size() == 0) check("unexpected_strobe", 16'd1, 16'd0);
        else begin
          cur_grade = exp_q.pop_front();
          check("grade", 16'(bus.grade), 16'(cur_grade));
        end
      end
      case (cur_grade)
        2'b00:   exp_ej = 3'b001;
        2'b01:   exp_ej = 3'b010;
        default: exp_ej = 3'b100;
      endcase
      if (ej != 3'b000) begin
        if (ej_len == 0) check("eject_onehot", 16'(ej), 16'(exp_ej));
        else if (ej != exp_ej) check("eject_stable", 16'(ej), 16'(exp_ej));
        ej_len++;
      end else if (ej_len != 0) begin
        check("eject_len", 16'(ej_len), 16'(EJECT_CYCLES));
        ej_len = 0;
      end
    end
  end

  // driver: one bean; bit i of t/p/c is the sensor level at sample i
  task automatic bean(input logic [3:0] t, input logic [3:0] p, input logic [3:0] c,
                      input int bp_samples, input int linger, input logic clr_at_grade,
                      input logic [1:0] g);
    exp_q.push_back(g);
    n_beans++;
    @(negedge clk);
    bus.bean_present = 1'b1;
    for (int i = 0; i < SAMPLES; i++) begin
      @(negedge clk);
      bus.sensor_tamano = t[i];
      bus.sensor_peso   = p[i];
      bus.sensor_color  = c[i];
      if (i >= bp_samples) bus.bean_present = 1'b0;
      if (i == SAMPLES - 1 && clr_at_grade) bus.clear_counts = 1'b1;
    end
    @(negedge clk);
    bus.sensor_tamano = 1'b0;
    bus.sensor_peso   = 1'b0;
    bus.sensor_color  = 1'b0;
    bus.clear_counts  = 1'b0;
    check("latency_strobe", 16'(bus.grade_valid), 16'd1);
    check("state_eject", 16'(state_dbg), 16'(EJECT));
    repeat (EJECT_CYCLES) @(negedge clk);
    check("state_wait_clear", 16'(state_dbg), 16'(WAIT_CLEAR));
    check("busy_wait_clear", 16'(bus.busy), 16'd1);
    repeat (linger) @(negedge clk);
    bus.bean_present = 1'b0;
    for (int k = 0; k < 20 && state_dbg != IDLE; k++) @(negedge clk);
    check("back_to_idle", 16'(state_dbg), 16'(IDLE));
  endtask

  task automatic check_counts(input string name, input int b, input int m, input int a);
    check({name, "_baja"},  16'(bus.cnt_baja),  16'(b));
    check({name, "_media"}, 16'(bus.cnt_media), 16'(m));
    check({name, "_alta"},  16'(bus.cnt_alta),  16'(a));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.bean_present  = 1'b0;
    bus.sensor_tamano = 1'b0;
    bus.sensor_peso   = 1'b0;
    bus.sensor_color  = 1'b0;
    bus.clear_counts  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 16'(state_dbg), 16'(IDLE));
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_grade", 16'(bus.grade), 16'd0);
    check("rst_ejects", 16'({bus.eject_alta, bus.eject_media, bus.eject_baja}), 16'd0);
    check_counts("rst_cnt", 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // clean ALTA
    bean(4'b1111, 4'b1111, 4'b1111, 4, 0, 1'b0, GRADE_ALTA);
    check_counts("alta1", 0, 0, 1);
    // noise: p 3 of 4, c 2 of 4 -> MEDIA; then p 2 of 4 -> BAJA
    bean(4'b1111, 4'b1101, 4'b0101, 4, 0, 1'b0, GRADE_MEDIA);
    bean(4'b1111, 4'b0101, 4'b0101, 4, 0, 1'b0, GRADE_BAJA);
    check_counts("noise", 1, 1, 1);
    // lingering bean graded once, then a fresh arrival graded again
    bean(4'b1111, 4'b1111, 4'b0000, 4, 27, 1'b0, GRADE_MEDIA);
    check_counts("linger", 1, 2, 1);
    bean(4'b1111, 4'b1111, 4'b0000, 4, 0, 1'b0, GRADE_MEDIA);
    check_counts("linger_again", 1, 3, 1);
    // bean drops after the 2nd sample; window still completes
    bean(4'b1111, 4'b1111, 4'b1111, 2, 0, 1'b0, GRADE_ALTA);
    // threshold edges: exactly VOTE_TH high votes 1, one fewer votes 0
    bean(4'b1111, 4'b1111, 4'b1011, 4, 0, 1'b0, GRADE_ALTA);
    bean(4'b0011, 4'b1111, 4'b1111, 4, 0, 1'b0, GRADE_BAJA);
    check_counts("threshold", 2, 3, 3);

    // clear while idle
    @(negedge clk);
    bus.clear_counts = 1'b1;
    @(negedge clk);
    bus.clear_counts = 1'b0;
    check_counts("clear_idle", 0, 0, 0);
    check("clear_keeps_grade", 16'(bus.grade), 16'(GRADE_BAJA));

    // saturation: 17 BAJA beans stop at 15
    for (int b = 1; b <= 17; b++) begin
      bean(4'b0000, 4'b1111, 4'b1111, 4, 0, 1'b0, GRADE_BAJA);
      if (b == 15) check("sat_at_15", 16'(bus.cnt_baja), 16'd15);
    end
    check_counts("sat_17", 15, 0, 0);
    // clear lands on the same edge as the 18th increment
    bean(4'b0000, 4'b1111, 4'b1111, 4, 0, 1'b1, GRADE_BAJA);
    check_counts("clear_wins", 0, 0, 0);

    // reset during the 4th eject cycle
    exp_q.push_back(GRADE_ALTA);
    n_beans++;
    @(negedge clk);
    bus.bean_present = 1'b1;
    for (int i = 0; i < SAMPLES; i++) begin
      @(negedge clk);
      bus.sensor_tamano = 1'b1;
      bus.sensor_peso   = 1'b1;
      bus.sensor_color  = 1'b1;
      if (i == SAMPLES - 1) bus.bean_present = 1'b0;
    end
    @(negedge clk);
    bus.sensor_tamano = 1'b0;
    bus.sensor_peso   = 1'b0;
    bus.sensor_color  = 1'b0;
    check("rst_test_strobe", 16'(bus.grade_valid), 16'd1);
    check("rst_test_cnt_alta", 16'(bus.cnt_alta), 16'd1);
    repeat (3) @(negedge clk);
    check("rst_test_eject4", 16'(bus.eject_alta), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ejects", 16'({bus.eject_alta, bus.eject_media, bus.eject_baja}), 16'd0);
    check("midrst_grade", 16'(bus.grade), 16'd0);
    check("midrst_busy", 16'(bus.busy), 16'd0);
    check("midrst_state", 16'(state_dbg), 16'(IDLE));
    check_counts("midrst_cnt", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_idle", 16'(state_dbg), 16'(IDLE));

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    check("strobe_count", 16'(strobes), 16'(n_beans));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clasificador_secuencial.md
Name: clasificador_secuencial

Overview:
- Sequential, parametrised successor to the combinational coffee-bean grader.
- Samples the size, weight and colour sensors over a configurable window and majority-votes each sensor to reject noise.
- Grades the bean BAJA/MEDIA/ALTA with the established rule, then drives a timed one-hot ejector pulse for that grade.
- Keeps saturating per-grade tallies. Sits between the raw sensor front-end and the sorting-gate actuators.

Parameters:
- SAMPLES, 4: sensor samples taken per bean (2..15).
- VOTE_TH, 3: minimum high samples for a sensor to vote 1. Legal range 1..SAMPLES; elaboration error otherwise.
- EJECT_CYCLES, 8: ejector pulse length in clocks (>=1).
- CNT_W, 16: width of each per-grade tally counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- bean_present  in  1  bean in the sensing station (level)
- sensor_tamano  in  1  size sensor
- sensor_peso  in  1  weight sensor
- sensor_color  in  1  colour sensor
- clear_counts  in  1  synchronous clear of all tallies
- busy  out  1  high whenever the FSM is not in IDLE
- grade_valid  out  1  one-cycle strobe; grade is new this cycle
- grade  out  2  00 BAJA, 01 MEDIA, 10 ALTA; holds until the next strobe
- eject_baja  out  1  BAJA gate actuator
- eject_media  out  1  MEDIA gate actuator
- eject_alta  out  1  ALTA gate actuator
- cnt_baja  out  CNT_W  BAJA tally
- cnt_media  out  CNT_W  MEDIA tally
- cnt_alta  out  CNT_W  ALTA tally

Behaviour:
- Reset (rst=1 at an edge): state IDLE; every output 0, including grade, ejects and counters; vote accumulators cleared. Reset mid-operation aborts the current bean with no strobe and no tally, and all ejects drop on that same edge.
- IDLE: when bean_present=1 at an edge -> SAMPLE; per-sensor accumulators cleared.
- SAMPLE: exactly SAMPLES cycles.
  - Each cycle, a sensor's accumulator increments if that sensor is 1.
  - bean_present is ignored in SAMPLE; the window always completes.
- Vote: a sensor's bit = (its accumulator, including the final sample) >= VOTE_TH.
- Grade rule on voted bits t/p/c:
  - t=0 or p=0 -> 00 (BAJA)
  - t=1, p=1, c=0 -> 01 (MEDIA)
  - t=1, p=1, c=1 -> 10 (ALTA)
  - 11 is never produced.
- SAMPLE -> EJECT, all registered and taking effect the same edge:
  - grade loaded, grade_valid=1 for one cycle.
  - The matching eject_* goes high.
  - The matching counter increments.
- Latency: grade_valid and the first eject cycle occur SAMPLES+1 cycles after the edge that saw bean_present=1 in IDLE.
- EJECT: exactly one eject_* is high for exactly EJECT_CYCLES cycles; the other two stay 0. Then -> WAIT_CLEAR.
- WAIT_CLEAR: hold until bean_present=0 at an edge -> IDLE. A bean that lingers is never graded twice.
- Minimum per-bean period: SAMPLES+EJECT_CYCLES+2 cycles.
- Counters: saturate at all-ones and never wrap.
  - clear_counts=1 zeroes all three next edge; it wins over a simultaneous increment.
  - clear_counts affects neither the FSM nor grade.
- busy=1 in SAMPLE, EJECT and WAIT_CLEAR.

Decomposition:
- Shared package clasif_pkg holds:
  - grade encodings GRADE_BAJA=2'b00, GRADE_MEDIA=2'b01, GRADE_ALTA=2'b10;
  - the FSM state enum IDLE, SAMPLE, EJECT, WAIT_CLEAR;
  - a grade-rule function (t,p,c)->grade, reused by the bench model.
- One sub-module, voto_mayoria: a single-sensor sample accumulator plus threshold compare, parametrised by SAMPLES/VOTE_TH, with clear and enable inputs; instantiated three times.

Test Plan (SAMPLES=4, VOTE_TH=3, EJECT_CYCLES=8, CNT_W=4):
- Clean ALTA: bean_present=1 and t=p=c=1 held -> grade_valid at cycle +5, grade=10, eject_alta high 8 cycles, cnt_alta=1, other ejects 0.
- Noise vote: t=1 all 4 samples; p high in 3 of 4 samples; c high in 2 of 4 -> grade=01 (MEDIA), eject_media 8 cycles. Repeat with p high in 2 of 4 -> grade=00.
- Lingering bean: bean_present held high for 40 cycles with t=p=1, c=0 -> exactly one grade_valid, cnt_media=1. After bean_present drops and rises again, a second grade follows.
- Saturation/clear: 17 consecutive BAJA beans -> cnt_baja=15, no wrap. clear_counts pulsed on the same edge as the 18th increment -> cnt_baja=0.
- Reset mid-eject: rst=1 during the 4th eject cycle -> next edge all ejects 0, grade=0, busy=0, counters 0, no further grade_valid.
- Bean drop in window: bean_present falls after the 2nd sample -> sampling still completes, grade_valid at cycle +5, FSM passes through WAIT_CLEAR straight to IDLE.
